dff_share_arbiter: RTL and testbench

//  Round-robin arbiter and write sequencer for one shared WIDTH-bit D flip-flop

---
 rtl/dff_share_arbiter.sv | 99 +++++++++
 tb/tb_dff_share_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter that sequences writes from NREQ requesters into one shared
// WIDTH-bit register, with bounded lock bursts and last-writer tracking.
module dff_share_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        q,
    output logic [$clog2(NREQ)-1:0] q_owner,
    output logic                    q_valid
);

    localparam int IW = $clog2(NREQ);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] cur;
    logic [IW-1:0] cur_inc;
    logic [IW-1:0] scan_ptr;
    logic [IW-1:0] win;
    logic [HW-1:0] hold_cnt;
    logic          write_en;
    logic          stay;

    // When leaving GRANT the scan starts just past the current owner, which is
    // exactly where rr_ptr is about to point.
    always_comb begin
        int idx;
        cur_inc  = (int'(cur) == NREQ - 1) ? '0 : cur + 1'b1;
        scan_ptr = (state == StGrant) ? cur_inc : rr_ptr;
        win      = scan_ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(scan_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[IW'(idx)]) win = IW'(idx);
        end
        write_en = (state == StGrant) && req[cur];
        stay     = write_en && lock[cur] && (int'(hold_cnt) < MAX_HOLD - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            gnt      <= '0;
            q        <= '0;
            q_owner  <= '0;
            q_valid  <= 1'b0;
            rr_ptr   <= '0;
            cur      <= '0;
            hold_cnt <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (|req) begin
                        state    <= StGrant;
                        cur      <= win;
                        gnt      <= NREQ'(1) << win;
                        hold_cnt <= '0;
                    end
                end
                StGrant: begin
                    // Only the granted slice is ever selected, so X elsewhere cannot leak.
                    if (write_en) begin
                        q       <= wdata[cur*WIDTH +: WIDTH];
                        q_owner <= cur;
                        q_valid <= 1'b1;
                    end
                    if (stay) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        rr_ptr   <= cur_inc;
                        hold_cnt <= '0;
                        if (|req) begin
                            cur <= win;
                            gnt <= NREQ'(1) << win;
                        end else begin
                            state <= StIdle;
                            gnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Self-checking bench for dff_share_arbiter: directed scenarios with literal
// expectations, then random traffic against a transaction-level reference model.
module tb_dff_share_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int H = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [1:0]     q_owner;
    logic           q_valid;

    int total = 0;
    int bad   = 0;

    // Reference model state: who holds the grant and how many writes they made in a row.
    int         m_busy, m_w, m_ptr, m_run, m_owner;
    logic [W-1:0] m_q;
    logic       m_valid;

    dff_share_arbiter #(.NREQ(N), .WIDTH(W), .MAX_HOLD(H)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .wdata   (wdata),
        .gnt     (gnt),
        .q       (q),
        .q_owner (q_owner),
        .q_valid (q_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    function automatic int scan(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_w = 0; m_ptr = 0; m_run = 0;
        m_q = '0; m_owner = 0; m_valid = 1'b0;
    endtask

    task automatic model_step();
        bit wr;
        if (m_busy == 0) begin
            if (req != 0) begin
                m_w = scan(req, m_ptr);
                m_busy = 1;
                m_run = 0;
            end
        end else begin
            wr = req[m_w];
            if (wr) begin
                m_q = wdata[m_w*W +: W];
                m_owner = m_w;
                m_valid = 1'b1;
                m_run++;
            end
            if (!(wr && lock[m_w] && m_run < H)) begin
                m_ptr = (m_w + 1) % N;
                if (req != 0) begin
                    m_w = scan(req, m_ptr);
                    m_run = 0;
                end else begin
                    m_busy = 0;
                end
            end
        end
    endtask

    task automatic model_check();
        logic [N-1:0] eg;
        eg = (m_busy != 0) ? (N'(1) << m_w) : '0;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("q", 32'(q), 32'(m_q));
        chk("q_owner", 32'(q_owner), 32'(m_owner));
        chk("q_valid", 32'(q_valid), 32'(m_valid));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_check();
    endtask

    logic [N-1:0] rot_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [W-1:0] rot_q [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [N-1:0] lck_g [4] = '{4'b0001, 4'b0001, 4'b0010, 4'b0001};

    initial begin
        rst = 1'b1; req = '0; lock = '0; wdata = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_q", 32'(q), 32'h0);
        chk("reset_valid", 32'(q_valid), 32'h0);
        chk("reset_owner", 32'(q_owner), 32'h0);

        // Single requester, other slices undriven X
        req = 4'b0001;
        wdata = {24'hxxxxxx, 8'hA5};
        cycle();
        chk("single_gnt", 32'(gnt), 32'h1);
        cycle();
        chk("single_q", 32'(q), 32'hA5);
        chk("single_owner", 32'(q_owner), 32'h0);
        chk("single_valid", 32'(q_valid), 32'h1);
        req = 4'b0000;
        cycle();
        chk("single_idle", 32'(gnt), 32'h0);

        // Reset in the middle of a grant, between edges
        req = 4'b0010;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        cycle();
        chk("pre_rst_gnt", 32'(gnt), 32'h2);
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_gnt", 32'(gnt), 32'h0);
        chk("midrst_q", 32'(q), 32'h0);
        chk("midrst_valid", 32'(q_valid), 32'h0);
        model_check();
        #1;
        rst = 1'b0;

        // Rotation from rr_ptr=0 after reset
        req = 4'b1111;
        lock = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk($sformatf("rot_gnt%0d", k), 32'(gnt), 32'(rot_g[k]));
            if (k > 0) chk($sformatf("rot_q%0d", k), 32'(q), 32'(rot_q[k-1]));
        end

        // Lock burst bounded by MAX_HOLD
        req = 4'b0011;
        lock = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk($sformatf("lock_gnt%0d", k), 32'(gnt), 32'(lck_g[k]));
        end

        // Abort: requester 0 drops while granted
        req = 4'b0010;
        lock = 4'b0000;
        cycle();
        chk("abort_gnt", 32'(gnt), 32'h2);
        chk("abort_q", 32'(q), 32'h22);
        chk("abort_owner", 32'(q_owner), 32'h1);

        // Wrap from rr_ptr=3 back to 0
        req = 4'b0100;
        cycle();
        chk("wrap_g2", 32'(gnt), 32'h4);
        req = 4'b1100;
        cycle();
        chk("wrap_g3", 32'(gnt), 32'h8);
        chk("wrap_q2", 32'(q), 32'h33);
        chk("wrap_owner2", 32'(q_owner), 32'h2);
        req = 4'b1001;
        cycle();
        chk("wrap_g0", 32'(gnt), 32'h1);
        chk("wrap_q3", 32'(q), 32'h44);

        // Random traffic; slices of non-requesting ports are sometimes X
        for (int n = 0; n < 3000; n++) begin
            req = N'($urandom_range(0, 15));
            lock = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) wdata[i*W +: W] = 'x;
                else wdata[i*W +: W] = W'($urandom);
            end
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                model_check();
                #1;
                rst = 1'b0;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
